// File: rtl/gray_to_binary_if.sv
// Gray-to-binary sample bus: Gray samples in, binary results out.
// master drives samples; slave (the converter) returns results.
interface gray_to_binary_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] gray_code;
  logic             out_valid;
  logic [WIDTH-1:0] binary_code;
  logic             step_err;
  logic             step_err_sticky;

  modport master (
    output in_valid,
    output gray_code,
    input  out_valid,
    input  binary_code,
    input  step_err,
    input  step_err_sticky
  );

  modport slave (
    input  in_valid,
    input  gray_code,
    output out_valid,
    output binary_code,
    output step_err,
    output step_err_sticky
  );
endinterface

// File: rtl/gray_to_binary.sv
// Registered Gray-to-binary converter, 1-cycle latency.
// GRAY_STEP_CHECK_EN builds the consecutive-sample adjacency check.
module gray_to_binary #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  gray_to_binary_if.slave     bus
);

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] r_bin;
  logic             r_out_valid;

  // b[i] is the XOR reduction of g[WIDTH-1:i]
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bin[i] = ^(bus.gray_code >> i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_bin <= w_bin;
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.binary_code = r_bin;

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] r_prev;
  logic             r_have_prev;
  logic             r_step_err;
  logic             r_sticky;
  logic [WIDTH-1:0] w_diff;
  logic             w_multi;

  assign w_diff  = bus.gray_code ^ r_prev;
  // more than one bit set iff clearing the lowest set bit leaves some
  assign w_multi = |(w_diff & (w_diff - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_step_err  <= 1'b0;
      r_sticky    <= 1'b0;
    end else begin
      r_step_err <= 1'b0;
      if (bus.in_valid) begin
        r_prev      <= bus.gray_code;
        r_have_prev <= 1'b1;
        if (r_have_prev && w_multi) begin
          r_step_err <= 1'b1;
          r_sticky   <= 1'b1;
        end
      end
    end
  end

  assign bus.step_err        = r_step_err;
  assign bus.step_err_sticky = r_sticky;
`else
  assign bus.step_err        = 1'b0;
  assign bus.step_err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_binary.sv
// Directed self-checking bench for gray_to_binary (WIDTH=8).
// Step-check expectations follow GRAY_STEP_CHECK_EN.
module tb_gray_to_binary;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  gray_to_binary_if #(.WIDTH(8)) bus ();

  gray_to_binary #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef GRAY_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.gray_code = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (bus.binary_code !== 8'h00) begin
        n_bad++;
        $display("FAIL rst_bin cyc%0d got %h want 00", c, bus.binary_code);
      end
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_ovld cyc%0d got %b want 0", c, bus.out_valid);
      end
      n_cmp++;
      if (bus.step_err !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_err cyc%0d got %b want 0", c, bus.step_err);
      end
      n_cmp++;
      if (bus.step_err_sticky !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_sticky cyc%0d got %b want 0", c,
                 bus.step_err_sticky);
      end
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_spot();
    logic [7:0] g [4];
    logic [7:0] b [4];
    g = '{8'h00, 8'h03, 8'h80, 8'hFF};
    b = '{8'h00, 8'h02, 8'hFF, 8'hAA};
    for (int k = 0; k < 4; k++) begin
      bus.in_valid  = 1'b1;
      bus.gray_code = g[k];
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.binary_code !== b[k]) begin
        n_bad++;
        $display("FAIL spot g=%h got v=%b b=%h want v=1 b=%h",
                 g[k], bus.out_valid, bus.binary_code, b[k]);
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    bit         seen [256];
    logic [7:0] exp_b;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    for (int k = 0; k < 256; k++) begin
      bus.in_valid  = 1'b1;
      bus.gray_code = 8'(k);
      exp_b[7] = bus.gray_code[7];
      for (int j = 6; j >= 0; j--) begin
        exp_b[j] = exp_b[j+1] ^ bus.gray_code[j];
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.binary_code !== exp_b) begin
        n_bad++;
        $display("FAIL sweep g=%h got v=%b b=%h want v=1 b=%h",
                 k[7:0], bus.out_valid, bus.binary_code, exp_b);
      end
      n_cmp++;
      if (seen[bus.binary_code] !== 1'b0) begin
        n_bad++;
        $display("FAIL sweep_dup g=%h got b=%h already seen want unique",
                 k[7:0], bus.binary_code);
      end
      seen[bus.binary_code] = 1'b1;
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_gaps();
    bus.in_valid  = 1'b1;
    bus.gray_code = 8'h06;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.binary_code !== 8'h04) begin
      n_bad++;
      $display("FAIL gap_first got v=%b b=%h want v=1 b=04",
               bus.out_valid, bus.binary_code);
    end
    bus.in_valid  = 1'b0;
    bus.gray_code = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.binary_code !== 8'h04) begin
        n_bad++;
        $display("FAIL gap_idle cyc%0d got v=%b b=%h want v=0 b=04",
                 c, bus.out_valid, bus.binary_code);
      end
    end
    bus.in_valid  = 1'b1;
    bus.gray_code = 8'h07;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.binary_code !== 8'h05) begin
      n_bad++;
      $display("FAIL gap_second got v=%b b=%h want v=1 b=05",
               bus.out_valid, bus.binary_code);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_step();
    logic [7:0] g  [7];
    logic [7:0] b  [7];
    logic       e  [7];
    logic       s  [7];
    g = '{8'h00, 8'h01, 8'h01, 8'h07, 8'hC0, 8'h80, 8'h00};
    b = '{8'h00, 8'h01, 8'h01, 8'h05, 8'h80, 8'hFF, 8'h00};
    e = '{1'b0, 1'b0, 1'b0, CHK, 1'b0, 1'b0, 1'b0};
    s = '{1'b0, 1'b0, 1'b0, CHK, 1'b0, 1'b0, 1'b0};
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) begin
        // idle cycle: pulse ends, sticky holds
        bus.in_valid = 1'b0;
        tick();
        n_cmp++;
        if (bus.step_err !== 1'b0 || bus.step_err_sticky !== CHK) begin
          n_bad++;
          $display("FAIL step_hold got e=%b s=%b want e=0 s=%b",
                   bus.step_err, bus.step_err_sticky, CHK);
        end
        // mid-sequence reset with a sample in flight
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.gray_code = 8'h3C;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.step_err_sticky !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.binary_code !== 8'h00) begin
          n_bad++;
          $display("FAIL step_rst got s=%b v=%b b=%h want s=0 v=0 b=00",
                   bus.step_err_sticky, bus.out_valid, bus.binary_code);
        end
      end
      bus.in_valid  = 1'b1;
      bus.gray_code = g[k];
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.binary_code !== b[k] ||
          bus.step_err !== e[k] || bus.step_err_sticky !== s[k]) begin
        n_bad++;
        $display("FAIL step g=%h got v=%b b=%h e=%b s=%b want v=1 b=%h e=%b s=%b",
                 g[k], bus.out_valid, bus.binary_code, bus.step_err,
                 bus.step_err_sticky, b[k], e[k], s[k]);
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.gray_code = 8'h00;
    test_reset();
    test_spot();
    test_sweep();
    test_gaps();
    test_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
